branch_predictor: RTL

Dynamic branch direction predictor for the DHRUT-V pipeline. It holds a direct-mapped table of 2-bit saturating counters. The fetch stage queries the table by PC. The execute stage writes back the real outcome produced by `branch_decision` (`o_branch`) to train the table. The block reports each misprediction one cycle after resolution and keeps running branch and misprediction counts for performance monitoring.

---
 rtl/branch_predictor.sv | 99 +++++++++
 1 files changed

// File: rtl/branch_predictor.sv
// Dynamic branch direction predictor: direct-mapped table of 2-bit saturating
// counters, trained by resolved branches, with mispredict pulse and perf counters.
module branch_predictor #(
  parameter int XLEN    = 32,
  parameter int ENTRIES = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            i_pred_valid,
  input  logic [XLEN-1:0] i_pred_pc,
  output logic            o_pred_valid,
  output logic            o_pred_taken,
  input  logic            i_res_valid,
  input  logic [XLEN-1:0] i_res_pc,
  input  logic            i_res_taken,
  input  logic            i_res_pred_taken,
  output logic            o_mispredict,
  output logic [31:0]     o_branch_count,
  output logic [31:0]     o_mispredict_count
);

  localparam int IDX = $clog2(ENTRIES);

  // Both ports are valid-only: a request is consumed on every rising edge where
  // its valid is high; there is no ready, no backpressure and no stall.

  logic [1:0]      table_q [ENTRIES];
  logic [1:0]      table_d [ENTRIES];
  logic            pred_valid_q, pred_valid_d;
  logic            pred_taken_q, pred_taken_d;
  logic            mispredict_q, mispredict_d;
  logic [31:0]     branch_count_q, branch_count_d;
  logic [31:0]     mispredict_count_q, mispredict_count_d;

  logic [IDX-1:0]  pred_idx;
  logic [IDX-1:0]  res_idx;
  logic [1:0]      res_cur;
  logic [1:0]      res_nxt;
  logic            res_miss;
  logic            unused_pc_bits;

  // Word-aligned PCs: bits [1:0] and everything above the index are ignored.
  assign pred_idx = i_pred_pc[IDX+1:2];
  assign res_idx  = i_res_pc[IDX+1:2];
  assign unused_pc_bits = ^{i_pred_pc[XLEN-1:IDX+2], i_pred_pc[1:0],
                            i_res_pc[XLEN-1:IDX+2], i_res_pc[1:0]};

  assign res_cur  = table_q[res_idx];
  assign res_miss = i_res_valid & (i_res_taken ^ i_res_pred_taken);

  always_comb begin
    res_nxt = res_cur;
    if (i_res_taken) begin
      if (res_cur != 2'b11) res_nxt = res_cur + 2'd1;
    end else begin
      if (res_cur != 2'b00) res_nxt = res_cur - 2'd1;
    end
  end

  // Prediction reads table_q, so a same-cycle update to the same index is not
  // bypassed: the predictor sees the old counter.
  always_comb begin
    table_d = table_q;
    if (i_res_valid) table_d[res_idx] = res_nxt;

    pred_valid_d       = i_pred_valid;
    pred_taken_d       = i_pred_valid & table_q[pred_idx][1];
    mispredict_d       = res_miss;
    branch_count_d     = branch_count_q;
    mispredict_count_d = mispredict_count_q;
    if (i_res_valid) branch_count_d = branch_count_q + 32'd1;
    if (res_miss)    mispredict_count_d = mispredict_count_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= 2'b01;
      pred_valid_q       <= 1'b0;
      pred_taken_q       <= 1'b0;
      mispredict_q       <= 1'b0;
      branch_count_q     <= 32'd0;
      mispredict_count_q <= 32'd0;
    end else begin
      for (int i = 0; i < ENTRIES; i++) table_q[i] <= table_d[i];
      pred_valid_q       <= pred_valid_d;
      pred_taken_q       <= pred_taken_d;
      mispredict_q       <= mispredict_d;
      branch_count_q     <= branch_count_d;
      mispredict_count_q <= mispredict_count_d;
    end
  end

  assign o_pred_valid       = pred_valid_q;
  assign o_pred_taken       = pred_taken_q;
  assign o_mispredict       = mispredict_q;
  assign o_branch_count     = branch_count_q;
  assign o_mispredict_count = mispredict_count_q;

endmodule
